// File: rtl/pio_led_pkg.sv
// Shared constants for the LED PIO: register word addresses and STATUS layout.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pio_led_pkg;

   // Word addresses on the lightweight bridge slave
   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_SET    = 3'd1;
   localparam logic [2:0] ADDR_CLR    = 3'd2;
   localparam logic [2:0] ADDR_TGL    = 3'd3;
   localparam logic [2:0] ADDR_BLINK  = 3'd4;
   localparam logic [2:0] ADDR_PERIOD = 3'd5;
   localparam logic [2:0] ADDR_STATUS = 3'd6;
   localparam logic [2:0] ADDR_RSVD   = 3'd7;

   // Bit of STATUS that carries the current blink phase
   localparam int STATUS_PHASE_BIT = 31;

endpackage

// File: rtl/pio_blink_timer.sv
// Blink engine: prescaler -> half-period counter -> phase flip-flop.
// Latency: phase toggles PERIOD*PRESCALE cycles after a period write.
// Backpressure: none; period_wr always wins over a same-cycle tick.
module pio_blink_timer #(
   parameter int PRESCALE = 50000,
   parameter int PERIOD_W = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [PERIOD_W-1:0] period,
   input  logic                period_wr,
   output logic                phase,
   output logic [PERIOD_W-1:0] hcnt
);

   // A prescaler of 1 still needs a one-bit register to keep the logic uniform
   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0]     ps_q, ps_d;
   logic [PERIOD_W-1:0] hcnt_q, hcnt_d;
   logic                phase_q, phase_d;
   logic                tick;
   logic                frozen;
   logic                half_done;

   assign frozen    = (period == '0);
   assign tick      = (ps_q == PS_LAST);
   assign half_done = (hcnt_q == (period - PERIOD_W'(1)));

   // Next-state: a period write restarts the engine; a zero period freezes it
   always_comb begin
      ps_d    = ps_q;
      hcnt_d  = hcnt_q;
      phase_d = phase_q;
      if (period_wr) begin
         ps_d    = '0;
         hcnt_d  = '0;
         phase_d = 1'b1;
      end else if (!frozen) begin
         if (tick) begin
            ps_d = '0;
            if (half_done) begin
               hcnt_d  = '0;
               phase_d = ~phase_q;
            end else begin
               hcnt_d = hcnt_q + PERIOD_W'(1);
            end
         end else begin
            ps_d = ps_q + PS_W'(1);
         end
      end
   end

   // Engine state registers, cleared asynchronously with phase parked high
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ps_q    <= '0;
         hcnt_q  <= '0;
         phase_q <= 1'b1;
      end else begin
         ps_q    <= ps_d;
         hcnt_q  <= hcnt_d;
         phase_q <= phase_d;
      end
   end

   // Frozen engine reports phase high so blinking bits simply follow DATA
   assign phase = frozen ? 1'b1 : phase_q;
   assign hcnt  = hcnt_q;

endmodule

// File: rtl/pio_led_ctrl.sv
// Avalon-MM LED PIO with atomic SET/CLEAR/TOGGLE ports and per-bit blink.
// Latency: writes visible one cycle after the write cycle; reads are zero-wait.
// Backpressure: none; the slave accepts every access without wait states.
module pio_led_ctrl
   import pio_led_pkg::*;
#(
   parameter int               WIDTH        = 10,
   parameter logic [WIDTH-1:0] RESET_VALUE  = {WIDTH{1'b1}},
   parameter int               PRESCALE     = 50000,
   parameter int               PERIOD_W     = 16,
   parameter int               PERIOD_RESET = 250
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   logic [WIDTH-1:0]    data_q, data_d;
   logic [WIDTH-1:0]    blink_q, blink_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic                period_wr;
   logic                wr;
   logic [WIDTH-1:0]    wd_data;
   logic [PERIOD_W-1:0] wd_period;
   logic                phase;
   logic [PERIOD_W-1:0] hcnt;
   logic                unused_wd;

   assign wr        = chipselect & ~write_n;
   assign wd_data   = writedata[WIDTH-1:0];
   assign wd_period = writedata[PERIOD_W-1:0];
   // Upper writedata bits are deliberately dropped for narrow configurations
   assign unused_wd = ^writedata;

   // Register-file next state; the atomic ports avoid software read-modify-write
   always_comb begin
      data_d    = data_q;
      blink_d   = blink_q;
      period_d  = period_q;
      period_wr = 1'b0;
      if (wr) begin
         case (address)
            ADDR_DATA:   data_d  = wd_data;
            ADDR_SET:    data_d  = data_q | wd_data;
            ADDR_CLR:    data_d  = data_q & ~wd_data;
            ADDR_TGL:    data_d  = data_q ^ wd_data;
            ADDR_BLINK:  blink_d = wd_data;
            ADDR_PERIOD: begin
               period_d  = wd_period;
               period_wr = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Register file storage with asynchronous reset to the configured values
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q   <= RESET_VALUE;
         blink_q  <= '0;
         period_q <= PERIOD_W'(PERIOD_RESET);
      end else begin
         data_q   <= data_d;
         blink_q  <= blink_d;
         period_q <= period_d;
      end
   end

   pio_blink_timer #(
      .PRESCALE (PRESCALE),
      .PERIOD_W (PERIOD_W)
   ) u_timer (
      .clk       (clk),
      .reset_n   (reset_n),
      .period    (period_q),
      .period_wr (period_wr),
      .phase     (phase),
      .hcnt      (hcnt)
   );

   // Zero-wait read mux; write-only ports alias DATA, reserved reads zero
   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA, ADDR_SET, ADDR_CLR, ADDR_TGL: readdata = 32'(data_q);
         ADDR_BLINK:  readdata = 32'(blink_q);
         ADDR_PERIOD: readdata = 32'(period_q);
         ADDR_STATUS: begin
            readdata[PERIOD_W-1:0]       = hcnt;
            readdata[STATUS_PHASE_BIT]   = phase;
         end
         default:     readdata = '0;
      endcase
   end

   // LED drive depends only on registers; blinking bits are gated by phase
   always_comb begin
      out_port = (data_q & ~blink_q) | (data_q & blink_q & {WIDTH{phase}});
   end

endmodule

// File: tb/tb_pio_led_ctrl.sv
module tb_pio_led_ctrl;
   import pio_led_pkg::*;

   localparam int W = 10;

   logic          clk;
   logic          reset_n;
   logic [2:0]    address;
   logic          chipselect;
   logic          write_n;
   logic [31:0]   writedata;
   logic [31:0]   readdata;
   logic [W-1:0]  out_port;

   pio_led_ctrl #(
      .WIDTH        (W),
      .RESET_VALUE  (10'h3FF),
      .PRESCALE     (2),
      .PERIOD_W     (16),
      .PERIOD_RESET (250)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Scoreboard queues: stimulus pushes, monitor pops
   logic [31:0]  rd_exp_q[$];
   string        rd_name_q[$];
   logic [W-1:0] out_exp_q[$];
   string        out_name_q[$];
   logic         rd_chk;
   logic         out_chk;
   int           n_chk;
   int           n_fail;

   // Monitor: samples on the falling edge whenever a check is presented
   always @(negedge clk) begin
      if (rd_chk) begin
         n_chk++;
         if (rd_exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rd_underflow: readdata=%08h with no expected entry", readdata);
         end else begin
            logic [31:0] e;
            string       nm;
            e  = rd_exp_q.pop_front();
            nm = rd_name_q.pop_front();
            if (readdata !== e) begin
               n_fail++;
               $display("FAIL %s: readdata got %08h expected %08h @%0t", nm, readdata, e, $time);
            end
         end
      end
      if (out_chk) begin
         n_chk++;
         if (out_exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL out_underflow: out_port=%03h with no expected entry", out_port);
         end else begin
            logic [W-1:0] e;
            string        nm;
            e  = out_exp_q.pop_front();
            nm = out_name_q.pop_front();
            if (out_port !== e) begin
               n_fail++;
               $display("FAIL %s: out_port got %03h expected %03h @%0t", nm, out_port, e, $time);
            end
         end
      end
   end

   task automatic exp_rd(input logic [2:0] a, input logic [31:0] e, input string nm);
      address = a;
      rd_exp_q.push_back(e);
      rd_name_q.push_back(nm);
      rd_chk = 1'b1;
   endtask

   task automatic exp_out(input logic [W-1:0] e, input string nm);
      out_exp_q.push_back(e);
      out_name_q.push_back(nm);
      out_chk = 1'b1;
   endtask

   // Advance one cycle; tasks always resume 1 time unit after a rising edge
   task automatic step();
      @(posedge clk);
      #1;
      rd_chk  = 1'b0;
      out_chk = 1'b0;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      step();
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_chk      = 0;
      n_fail     = 0;
      rd_chk     = 1'b0;
      out_chk    = 1'b0;
      reset_n    = 1'b0;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      @(posedge clk);
      #1;

      // Reset state, sampled while reset is still held
      exp_out(10'h3FF, "rst_out");
      exp_rd(ADDR_DATA, 32'h0000_03FF, "rst_data");
      step();
      exp_rd(ADDR_BLINK, 32'h0, "rst_blink");
      step();
      reset_n = 1'b1;
      exp_rd(ADDR_PERIOD, 32'd250, "rst_period");
      exp_out(10'h3FF, "rst_out2");
      step();
      exp_rd(ADDR_RSVD, 32'h0, "rst_rsvd");
      step();

      // Atomic ports: old value during the write cycle, new value one cycle later
      exp_out(10'h3FF, "data_pre");
      bus_write(ADDR_DATA, 32'h0F0);
      exp_out(10'h0F0, "data_post");
      exp_rd(ADDR_DATA, 32'h0F0, "data_rd");
      step();
      exp_out(10'h0F0, "set_pre");
      bus_write(ADDR_SET, 32'h003);
      exp_out(10'h0F3, "set_post");
      exp_rd(ADDR_SET, 32'h0F3, "set_rd");
      step();
      exp_out(10'h0F3, "clr_pre");
      bus_write(ADDR_CLR, 32'h010);
      exp_out(10'h0E3, "clr_post");
      exp_rd(ADDR_CLR, 32'h0E3, "clr_rd");
      step();
      exp_out(10'h0E3, "tgl_pre");
      bus_write(ADDR_TGL, 32'h201);
      exp_out(10'h2E2, "tgl_post");
      exp_rd(ADDR_TGL, 32'h2E2, "tgl_rd");
      step();

      // Reserved address swallows writes and reads zero
      bus_write(ADDR_RSVD, 32'hFFFF_FFFF);
      exp_rd(ADDR_DATA, 32'h2E2, "rsvd_nowrite");
      step();
      exp_rd(ADDR_RSVD, 32'h0, "rsvd_rd");
      step();

      // Blink: PRESCALE=2, PERIOD=3 -> 6 cycles high, 6 low on bit 0
      bus_write(ADDR_DATA, 32'h3FF);
      bus_write(ADDR_BLINK, 32'h001);
      bus_write(ADDR_PERIOD, 32'd3);
      for (int k = 0; k < 18; k++) begin
         if (k < 6 || k >= 12) exp_out(10'h3FF, "blink_hi");
         else                  exp_out(10'h3FE, "blink_lo");
         if (k == 0) exp_rd(ADDR_STATUS, 32'h8000_0000, "status_k0");
         if (k == 2) exp_rd(ADDR_STATUS, 32'h8000_0001, "status_k2");
         if (k == 7) exp_rd(ADDR_STATUS, 32'h0000_0000, "status_k7");
         step();
      end
      // Now in phase 0 right after a toggle; walk to the next tick with hcnt=1
      exp_out(10'h3FE, "ph0_a");
      exp_rd(ADDR_STATUS, 32'h0000_0000, "status_p0_a");
      step();
      exp_rd(ADDR_STATUS, 32'h0000_0000, "status_p0_b");
      step();
      exp_rd(ADDR_STATUS, 32'h0000_0001, "status_p0_c");
      step();
      // Tick cycle: PERIOD write must win over the tick
      exp_out(10'h3FE, "ph0_wr");
      bus_write(ADDR_PERIOD, 32'd3);
      for (int k = 0; k < 12; k++) begin
         if (k < 6) exp_out(10'h3FF, "rewr_hi");
         else       exp_out(10'h3FE, "rewr_lo");
         if (k == 0) exp_rd(ADDR_STATUS, 32'h8000_0000, "rewr_status");
         step();
      end

      // PERIOD truncation to PERIOD_W bits
      bus_write(ADDR_PERIOD, 32'h0001_0005);
      exp_rd(ADDR_PERIOD, 32'h5, "period_trunc");
      step();

      // PERIOD=0 freezes the engine and blinking bits follow DATA
      bus_write(ADDR_PERIOD, 32'h0);
      bus_write(ADDR_BLINK, 32'h3FF);
      bus_write(ADDR_DATA, 32'h155);
      for (int k = 0; k < 8; k++) begin
         exp_out(10'h155, "frozen_out");
         exp_rd(ADDR_STATUS, 32'h8000_0000, "frozen_status");
         step();
      end

      // Asynchronous reset in the middle of phase 0
      bus_write(ADDR_PERIOD, 32'd3);
      for (int k = 0; k < 7; k++) begin
         if (k < 6) exp_out(10'h155, "pre_rst_hi");
         else       exp_out(10'h000, "pre_rst_lo");
         step();
      end
      #2;
      reset_n = 1'b0;
      exp_out(10'h3FF, "async_rst_out");
      exp_rd(ADDR_BLINK, 32'h0, "async_rst_blink");
      step();
      reset_n = 1'b1;
      exp_out(10'h3FF, "post_rst_out");
      exp_rd(ADDR_PERIOD, 32'd250, "post_rst_period");
      step();
      exp_rd(ADDR_DATA, 32'h3FF, "post_rst_data");
      step();

      if (rd_exp_q.size() != 0 || out_exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL leftover: %0d read and %0d out entries unchecked, expected 0",
                  rd_exp_q.size(), out_exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pio_led_ctrl.md
# pio_led_ctrl

Parametrised Avalon-MM output PIO for the HPS-to-FPGA lightweight bridge, the next generation of the fixed 10-bit LED port. It adds configurable width and reset value, atomic SET/CLEAR/TOGGLE write ports, and a per-bit hardware blink engine with a programmable period. Typical use is driving the DE1-SoC LEDR bank from HPS software without read-modify-write races.

## Interface
- WIDTH, 10: output bits, 1..32.
- RESET_VALUE, all ones (WIDTH bits): DATA value after reset.
- PRESCALE, 50000: clk cycles per blink tick, ≥1. At 50 MHz, 1 tick is 1 ms.
- PERIOD_W, 16: width of the PERIOD register, 1..31.
- PERIOD_RESET, 250: PERIOD value after reset.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  write strobe, active-low; qualified by chipselect.
- writedata  in  32  write data; bits above WIDTH/PERIOD_W are ignored.
- readdata  out  32  read data, zero-extended.
- out_port  out  WIDTH  LED drive.

## Operation
- Write strobe: wr = chipselect & ~write_n. Reads have no side effects and no wait states.
- Register map. Reads of the write-only ports 1–3 return DATA.
  - 0 DATA (RW): data <= wd.
  - 1 SET (W): data <= data | wd.
  - 2 CLEAR (W): data <= data & ~wd.
  - 3 TOGGLE (W): data <= data ^ wd.
  - 4 BLINK_EN (RW): per-bit blink mask.
  - 5 PERIOD (RW): half-period, in ticks.
  - 6 STATUS (R): bit 31 = phase, bits [PERIOD_W-1:0] = half-period counter.
  - 7 reserved: reads 0, writes are ignored.
- out_port[i] = blink_en[i] ? (data[i] & phase) : data[i]. A blinking bit is lit only when its DATA bit is 1 and phase is 1.
- Blink engine:
  - The prescaler counts 0..PRESCALE-1 and asserts tick on the wrap cycle.
  - On each tick, hcnt increments.
  - When hcnt == PERIOD-1 and tick is asserted: hcnt <= 0 and phase toggles.
- PERIOD = 0: the engine is frozen (prescaler, hcnt and phase held), phase is forced to 1, and out_port = data.
- A write to PERIOD clears the prescaler and hcnt and sets phase = 1 in the same edge. On a tick in that same cycle, the write wins.
- Writes to DATA, SET, CLEAR, TOGGLE and BLINK_EN do not disturb the engine.
- Reset values:
  - data = RESET_VALUE, blink_en = 0, period = PERIOD_RESET.
  - prescaler = 0, hcnt = 0, phase = 1.
  - out_port = RESET_VALUE.
  - readdata follows the address decode combinationally; it reads RESET_VALUE at address 0 while reset is held.
- Reset asserted mid-blink returns all state to the reset values immediately (asynchronously), with no glitch beyond that transition.

## Timing
- Write latency: a register and out_port update on the clk edge that samples wr. They are visible one cycle after the write cycle.
- Read latency 0: readdata is combinational from address and registers, valid in the cycle address is presented.
- out_port is a function of registers only. It has no combinational path from bus inputs.
- Blink half-period = PERIOD × PRESCALE clk cycles, exactly. Full cycle = 2 × that.
- The first phase toggle after a PERIOD write occurs PERIOD × PRESCALE cycles after the write edge.
- PRESCALE = 1: tick every cycle. PERIOD = 1 with PRESCALE = 1: phase toggles every cycle.
- hcnt, prescaler and phase wrap without overflow for all legal parameters. Writes of PERIOD above 2^PERIOD_W−1 truncate.

## Structure
- Package pio_led_pkg holds:
  - the address constants ADDR_DATA, ADDR_SET, ADDR_CLR, ADDR_TGL, ADDR_BLINK, ADDR_PERIOD, ADDR_STATUS;
  - the STATUS phase bit index (31).
- Sub-module pio_blink_timer, parameters PRESCALE and PERIOD_W:
  - inputs: clk, reset_n, period, period_wr;
  - outputs: phase, hcnt.
- The top level holds the register file, the bus decode and the out_port mux.

## Test plan
- Reset, WIDTH=10: out_port=0x3FF; read addr 0 = 0x000003FF; addr 4 = 0; addr 5 = 250.
- DATA=0x0F0, then SET 0x003, CLEAR 0x010, TOGGLE 0x201 -> reads 0x0F3, 0x0E3, 0x2E2. Each out_port change occurs one cycle after its write.
- PRESCALE=2, PERIOD=3, BLINK_EN=0x001, DATA=0x3FF -> out_port[0] is high 6 cycles then low 6 cycles, repeating; bits [9:1] stay high.
- PERIOD write coincident with tick, mid-phase-0 -> phase=1 next cycle, STATUS hcnt=0, next toggle exactly PERIOD×PRESCALE cycles later.
- PERIOD=0 with BLINK_EN=0x3FF, DATA=0x155 -> out_port constantly 0x155; the STATUS counter is frozen.
- reset_n pulsed low mid-blink (asynchronous, between edges) -> out_port returns to 0x3FF immediately and blink_en reads 0.
